// File: rtl/data_mem_nport_if.sv
// Request/response bundle for data_mem_nport.
// master: drives req_valid/req_we/req_size/req_signed/req_addr/req_wdata,
//         observes req_ready and resp_valid/resp_rdata/resp_err.
// slave:  the memory side of the same signals.
// All per-port fields are packed with port p at [W*p +: W].
interface data_mem_nport_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]    req_valid;
  logic [NUM_PORTS-1:0]    req_ready;
  logic [NUM_PORTS-1:0]    req_we;
  logic [2*NUM_PORTS-1:0]  req_size;
  logic [NUM_PORTS-1:0]    req_signed;
  logic [32*NUM_PORTS-1:0] req_addr;
  logic [32*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]    resp_valid;
  logic [32*NUM_PORTS-1:0] resp_rdata;
  logic [NUM_PORTS-1:0]    resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_nport.sv
// N-port byte-addressed data memory with registered, handshaked responses.
// After reset an INIT sequence clears one aligned word per cycle; requests
// are accepted only in RUN. Loads support byte/half/word with sign or zero
// extension; misaligned or size-11 requests return err with zero data and
// leave the memory untouched. Same-cycle store conflicts resolve per byte
// in favour of the highest-indexed port.
// Optional macro MEM_WR_BYPASS_EN: same-cycle loads observe same-cycle
// stores (write-first); when undefined, loads return pre-store contents.
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   bus        data_mem_nport_if.slave request/response bundle
//   init_done  high once the clear sequence has completed
//
// state | meaning
// INIT  | clearing word clr_cnt, requests not accepted
// RUN   | ready on all ports, normal operation
module data_mem_nport #(
  parameter int NUM_PORTS   = 3,
  parameter int DEPTH_BYTES = 32,
  parameter int RD_LAT      = 1
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_nport_if.slave bus,
  output logic            init_done
);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic          clr_en;
  logic          run;

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_en      = 1'b0;
    case (state)
      ST_INIT: begin
        clr_en      = 1'b1;
        clr_cnt_nxt = clr_cnt + CW'(1);
        if (clr_cnt == CW'(WORDS - 1)) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Gated with reset so nothing is accepted in the reset cycle itself.
  assign run           = (state == ST_RUN) && !reset;
  assign init_done     = run;
  assign bus.req_ready = {NUM_PORTS{run}};

  // Per-port decode
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] err;
  logic [AW-1:0]        base   [NUM_PORTS];
  logic [2:0]           nbytes [NUM_PORTS];
  logic                 unused_addr_hi;

  always_comb begin
    accept         = '0;
    err            = '0;
    unused_addr_hi = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      base[p]        = bus.req_addr[32*p +: AW];
      accept[p]      = bus.req_valid[p] & run;
      unused_addr_hi = unused_addr_hi ^ (^bus.req_addr[32*p+AW +: 32-AW]);
      case (bus.req_size[2*p +: 2])
        2'b00:   begin nbytes[p] = 3'd1; err[p] = 1'b0;            end
        2'b01:   begin nbytes[p] = 3'd2; err[p] = base[p][0];      end
        2'b10:   begin nbytes[p] = 3'd4; err[p] = |base[p][1:0];   end
        default: begin nbytes[p] = 3'd0; err[p] = 1'b1;            end
      endcase
    end
  end

  // Write plan: ascending port order so the highest-indexed port wins
  // each byte it touches.
  logic [DEPTH_BYTES-1:0] wr_en;
  logic [7:0]             wr_val [DEPTH_BYTES];

  always_comb begin
    logic [AW-1:0] widx;
    wr_en = '0;
    widx  = '0;
    for (int b = 0; b < DEPTH_BYTES; b++) wr_val[b] = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < 4; k++) begin
        widx = base[p] + AW'(k);
        if (accept[p] && bus.req_we[p] && !err[p] && (k < int'(nbytes[p]))) begin
          wr_en[widx]  = 1'b1;
          wr_val[widx] = bus.req_wdata[32*p + 8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < DEPTH_BYTES; b++) begin
      if (clr_en && ((b / 4) == int'(clr_cnt))) mem[b] <= 8'h00;
      else if (wr_en[b])                        mem[b] <= wr_val[b];
    end
  end

  // Load data, sampled in the acceptance cycle
  logic [32*NUM_PORTS-1:0] ld_data;

  always_comb begin
    logic [AW-1:0] ridx;
    logic [7:0]    rbyte;
    logic [31:0]   raw;
    logic [31:0]   ld;
    logic          sx;
    ld_data = '0;
    ridx    = '0;
    rbyte   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      raw = '0;
      for (int k = 0; k < 4; k++) begin
        ridx  = base[p] + AW'(k);
        rbyte = mem[ridx];
`ifdef MEM_WR_BYPASS_EN
        if (wr_en[ridx]) rbyte = wr_val[ridx];
`else
`endif
        raw[8*k +: 8] = rbyte;
      end
      sx = bus.req_signed[p];
      case (bus.req_size[2*p +: 2])
        2'b00:   ld = {{24{sx & raw[7]}}, raw[7:0]};
        2'b01:   ld = {{16{sx & raw[15]}}, raw[15:0]};
        2'b10:   ld = raw;
        default: ld = '0;
      endcase
      if (!accept[p] || bus.req_we[p] || err[p]) ld = '0;
      ld_data[32*p +: 32] = ld;
    end
  end

  // Response stage(s)
  logic [NUM_PORTS-1:0]    s1_valid, s1_err;
  logic [32*NUM_PORTS-1:0] s1_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= '0;
      s1_err   <= '0;
      s1_rdata <= '0;
    end else begin
      s1_valid <= accept;
      s1_err   <= accept & err;
      s1_rdata <= ld_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NUM_PORTS-1:0]    s2_valid, s2_err;
      logic [32*NUM_PORTS-1:0] s2_rdata;
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid <= '0;
          s2_err   <= '0;
          s2_rdata <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          s2_rdata <= s1_rdata;
        end
      end
      assign bus.resp_valid = s2_valid;
      assign bus.resp_err   = s2_err;
      assign bus.resp_rdata = s2_rdata;
    end else begin : g_lat1
      assign bus.resp_valid = s1_valid;
      assign bus.resp_err   = s1_err;
      assign bus.resp_rdata = s1_rdata;
    end
  endgenerate
endmodule

// File: tb/tb_data_mem_nport.sv
module tb_data_mem_nport;
  localparam int NP     = 3;
  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;
  localparam int WORDS  = DEPTH / 4;
`ifdef MEM_WR_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h00000000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done;

  data_mem_nport_if #(.NUM_PORTS(NP)) bus();

  data_mem_nport #(.NUM_PORTS(NP), .DEPTH_BYTES(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: byte array plus a queue of expected responses.
  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
    logic        err;
    bit          has_c;
    logic [31:0] cdata;
    logic        cerr;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  pend_mem [DEPTH];
  bit          run = 0;
  int          init_cnt = 0;
  int          cyc = 0;
  bit          dir_en [NP];
  logic [31:0] dir_d  [NP];
  logic        dir_e  [NP];

  function automatic int size_bytes(logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(logic [1:0] sz, logic [31:0] a);
    int n = size_bytes(sz);
    if (n == 0) return 0;
    return (a % n) == 0;
  endfunction

  function automatic logic [31:0] ext(logic [31:0] v, int bits, bit sgn);
    logic [31:0] m;
    if (bits == 32) return v;
    m = (32'd1 << bits) - 32'd1;
    v = v & m;
    if (sgn && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  task automatic model_pre();
    bit   exp_rdy;
    bit   acc [NP];
    logic [7:0] nm [DEPTH];
    exp_rdy = run && !reset;
    chk("req_ready", 32'(bus.req_ready), exp_rdy ? 32'((1 << NP) - 1) : 32'd0);
    chk("init_done", 32'(init_done), 32'(exp_rdy));
    nm = ref_mem;
    for (int p = 0; p < NP; p++) begin
      acc[p] = exp_rdy && bus.req_valid[p];
      if (dir_en[p] && !acc[p]) chk($sformatf("dir_accept[%0d]", p), 32'd0, 32'd1);
    end
    for (int p = 0; p < NP; p++) begin
      logic [1:0]  sz = bus.req_size[2*p +: 2];
      logic [31:0] a  = bus.req_addr[32*p +: 32];
      logic [31:0] wd = bus.req_wdata[32*p +: 32];
      if (acc[p] && bus.req_we[p] && legal(sz, a))
        for (int k = 0; k < size_bytes(sz); k++)
          nm[((a % DEPTH) + k) % DEPTH] = wd[8*k +: 8];
    end
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        exp_t        e;
        logic [1:0]  sz = bus.req_size[2*p +: 2];
        logic [31:0] a  = bus.req_addr[32*p +: 32];
        logic [31:0] v  = 0;
        int          n  = size_bytes(sz);
        e.port = p; e.due = cyc + RD_LAT;
        e.err  = !legal(sz, a);
        if (!e.err && !bus.req_we[p]) begin
          for (int k = 0; k < n; k++) begin
            int i = ((a % DEPTH) + k) % DEPTH;
`ifdef MEM_WR_BYPASS_EN
            v = v + (32'(nm[i]) << (8 * k));
`else
            v = v + (32'(ref_mem[i]) << (8 * k));
`endif
          end
          v = ext(v, 8 * n, bus.req_signed[p]);
        end
        e.data  = v;
        e.has_c = dir_en[p]; e.cdata = dir_d[p]; e.cerr = dir_e[p];
        q.push_back(e);
      end
    end
    pend_mem = nm;
  endtask

  task automatic model_post();
    if (reset) begin
      run = 0; init_cnt = 0; q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    end else begin
      ref_mem = pend_mem;
      if (!run) begin
        init_cnt++;
        if (init_cnt == WORDS) run = 1;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NP; p++) begin
      int idx;
      bit ev;
      idx = -1;
      for (int i = 0; i < q.size(); i++)
        if (q[i].port == p) begin idx = i; break; end
      ev = (idx >= 0) && (q[idx].due == cyc);
      chk($sformatf("resp_valid[%0d]", p), 32'(bus.resp_valid[p]), 32'(ev));
      if (ev) begin
        chk($sformatf("resp_rdata[%0d]", p), bus.resp_rdata[32*p +: 32], q[idx].data);
        chk($sformatf("resp_err[%0d]", p), 32'(bus.resp_err[p]), 32'(q[idx].err));
        if (q[idx].has_c) begin
          chk($sformatf("dir_rdata[%0d]", p), bus.resp_rdata[32*p +: 32], q[idx].cdata);
          chk($sformatf("dir_err[%0d]", p), 32'(bus.resp_err[p]), 32'(q[idx].cerr));
        end
        q.delete(idx);
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_pre();
    @(posedge clk);
    model_post();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr_reqs();
    bus.req_valid = '0; bus.req_we = '0; bus.req_size = '0; bus.req_signed = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int p = 0; p < NP; p++) begin dir_en[p] = 0; dir_d[p] = 0; dir_e[p] = 0; end
  endtask

  task automatic req(int p, bit we, logic [1:0] sz, bit sg, logic [31:0] a,
                     logic [31:0] wd, bit ce, logic [31:0] cd, bit cerr);
    bus.req_valid[p]          = 1'b1;
    bus.req_we[p]             = we;
    bus.req_size[2*p +: 2]    = sz;
    bus.req_signed[p]         = sg;
    bus.req_addr[32*p +: 32]  = a;
    bus.req_wdata[32*p +: 32] = wd;
    dir_en[p] = ce; dir_d[p] = cd; dir_e[p] = cerr;
  endtask

  task automatic wait_init(string tag);
    int n = 0;
    while (!bus.req_ready[0] && n < 20) begin cycle(); n++; end
    chk(tag, n, WORDS);
  endtask

  task automatic one(); cycle(); clr_reqs(); endtask

  initial begin
    clr_reqs();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    pend_mem = ref_mem;
    @(negedge clk);
    repeat (2) cycle();
    reset = 1'b0;
    wait_init("init_cycles");

    req(0, 0, 2'b10, 0, 32'h0, 0, 1, 32'h0, 0); one();

    req(0, 1, 2'b10, 0, 32'h4, 32'h80FF7F01, 0, 0, 0); one();
    req(0, 0, 2'b00, 1, 32'h4, 0, 1, 32'h00000001, 0);
    req(1, 0, 2'b00, 1, 32'h6, 0, 1, 32'hFFFFFFFF, 0);
    req(2, 0, 2'b01, 0, 32'h6, 0, 1, 32'h000080FF, 0); one();
    req(0, 0, 2'b01, 1, 32'h6, 0, 1, 32'hFFFF80FF, 0);
    req(1, 0, 2'b10, 1, 32'h4, 0, 1, 32'h80FF7F01, 0); one();

    req(0, 1, 2'b10, 0, 32'h8, 32'h11111111, 0, 0, 0);
    req(2, 1, 2'b00, 0, 32'h9, 32'h000000AA, 0, 0, 0); one();
    req(1, 0, 2'b10, 0, 32'h8, 0, 1, 32'h1111AA11, 0); one();

    req(1, 1, 2'b10, 0, 32'hC, 32'hDEADBEEF, 0, 0, 0);
    req(0, 0, 2'b10, 0, 32'hC, 0, 1, BYP_EXP, 0); one();

    req(0, 0, 2'b10, 0, 32'h2, 0, 1, 32'h0, 1);
    req(1, 1, 2'b01, 0, 32'h3, 32'h0000BEEF, 1, 32'h0, 1);
    req(2, 0, 2'b11, 0, 32'h0, 0, 1, 32'h0, 1); one();
    req(0, 0, 2'b10, 0, 32'h0, 0, 1, 32'h00000000, 0);
    req(1, 0, 2'b10, 0, 32'h4, 0, 1, 32'h80FF7F01, 0); one();

    req(1, 1, 2'b00, 0, 32'h25, 32'h0000005A, 0, 0, 0); one();
    req(0, 0, 2'b00, 0, 32'h5, 0, 1, 32'h0000005A, 0);
    req(2, 0, 2'b10, 0, 32'hE4, 0, 1, 32'h80FF5A01, 0); one();
    repeat (RD_LAT + 1) cycle();

    // reset in the cycle after acceptance: response must be discarded
    req(0, 0, 2'b10, 0, 32'h4, 0, 0, 0, 0); one();
    reset = 1'b1; cycle(); reset = 1'b0;
    wait_init("reinit_cycles");
    for (int w = 0; w < WORDS; w += NP) begin
      for (int p = 0; p < NP; p++)
        if (w + p < WORDS) req(p, 0, 2'b10, 0, 32'(4 * (w + p)), 0, 1, 32'h0, 0);
      one();
    end
    repeat (RD_LAT + 1) cycle();

    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NP; p++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        case ($urandom_range(0, 7))
          0, 1:    sz = 2'b00;
          2, 3:    sz = 2'b01;
          7:       sz = 2'b11;
          default: sz = 2'b10;
        endcase
        a = $urandom;
        if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~32'(size_bytes(sz) - 1);
        if ($urandom_range(0, 3) != 0) a = a % 64;
        if ($urandom_range(0, 3) != 0)
          req(p, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom, 0, 0, 0);
      end
      one();
    end
    reset = 1'b0;
    repeat (RD_LAT + 2) cycle();
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
